seg_ser_rx: RTL and testbench

- Receive-side counterpart of the segment serial drive path. It deserializes the 74HC595-style three-wire stream (data_ser, srclk, rclk) back into parallel frames inside the sys_clk domain.
- Used on the bench/loopback board to verify display traffic, and as the input stage of a secondary display that is slaved over the same three wires.
- Inputs are asynchronous to sys_clk and are oversampled.

---
 rtl/seg_ser_rx_if.sv | 25 ++
 rtl/seg_ser_rx.sv | 201 ++++++++++++++++++++
 tb/tb_seg_ser_rx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_ser_rx_if.sv
// Three-wire 74HC595-style serial link plus the recovered-frame outputs of its receiver.
// master drives the serial wires and observes the frames; slave is the receiver.
interface seg_ser_rx_if #(
    parameter int FRAME_BITS = 16
);
    logic                  data_ser;
    logic                  srclk;
    logic                  rclk;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  frame_err;
    logic                  timeout_err;
    logic [31:0]           disp_word;
    logic                  seg_unknown;

    modport master (
        output data_ser, srclk, rclk,
        input  frame_data, frame_valid, frame_err, timeout_err, disp_word, seg_unknown
    );

    modport slave (
        input  data_ser, srclk, rclk,
        output frame_data, frame_valid, frame_err, timeout_err, disp_word, seg_unknown
    );
endinterface

// File: rtl/seg_ser_rx.sv
// Oversampling deserializer for a 74HC595-style stream (data_ser/srclk/rclk) into sys_clk frames.
// Optional 7-segment decoder into an 8-digit hex word is built when SEG_RX_DECODE_EN is defined.
module seg_ser_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int TIMEOUT     = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    seg_ser_rx_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] BITS_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    // Per stage: bit 2 = data_ser, bit 1 = srclk, bit 0 = rclk.
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic [2:0]                  synced;
    logic [1:0]                  dly_reg;
    logic                        srclk_rise_reg;
    logic                        rclk_rise_reg;
    logic                        data_bit_reg;

    assign synced = sync_reg[SYNC_STAGES-1];

    // Rise flags are registered together with the data bit so they stay aligned.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync_reg       <= '0;
            dly_reg        <= '0;
            srclk_rise_reg <= 1'b0;
            rclk_rise_reg  <= 1'b0;
            data_bit_reg   <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], {bus.data_ser, bus.srclk, bus.rclk}};
            dly_reg        <= synced[1:0];
            srclk_rise_reg <= synced[1] & ~dly_reg[1];
            rclk_rise_reg  <= synced[0] & ~dly_reg[0];
            data_bit_reg   <= synced[2];
        end
    end

    state_t                state_reg, state_next;
    logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next;
    logic [FRAME_BITS-1:0] frame_data_reg, frame_data_next;
    logic                  frame_valid_reg, frame_valid_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  timeout_err_reg, timeout_err_next;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            shreg_reg       <= '0;
            bit_cnt_reg     <= '0;
            tmo_cnt_reg     <= '0;
            frame_data_reg  <= '0;
            frame_valid_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shreg_reg       <= shreg_next;
            bit_cnt_reg     <= bit_cnt_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            frame_data_reg  <= frame_data_next;
            frame_valid_reg <= frame_valid_next;
            frame_err_reg   <= frame_err_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        shreg_next       = shreg_reg;
        bit_cnt_next     = bit_cnt_reg;
        tmo_cnt_next     = '0;
        frame_data_next  = frame_data_reg;
        frame_valid_next = 1'b0;
        frame_err_next   = 1'b0;
        timeout_err_next = 1'b0;

        // Latch uses the pre-shift register, so a coincident shift belongs to the next frame.
        if (rclk_rise_reg) begin
            frame_data_next  = shreg_reg;
            frame_valid_next = 1'b1;
            frame_err_next   = (bit_cnt_reg != BITS_FULL);
            bit_cnt_next     = '0;
        end

        if (srclk_rise_reg) begin
            shreg_next = {shreg_reg[FRAME_BITS-2:0], data_bit_reg};
            if (rclk_rise_reg) begin
                bit_cnt_next = CNT_W'(1);
            end else if (bit_cnt_reg != BITS_SAT) begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (srclk_rise_reg) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (srclk_rise_reg) begin
                    state_next = ST_SHIFT;
                end else if (rclk_rise_reg) begin
                    state_next = ST_IDLE;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next       = ST_IDLE;
                    timeout_err_next = 1'b1;
                    bit_cnt_next     = '0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.frame_data  = frame_data_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.frame_err   = frame_err_reg;
    assign bus.timeout_err = timeout_err_reg;

`ifdef SEG_RX_DECODE_EN
    generate
        if (FRAME_BITS == 16) begin : g_dec
            logic [7:0]  pat;
            logic [7:0]  sel;
            logic [3:0]  nib;
            logic        known;
            logic        sel_ok;
            logic        upd;
            logic        dec_ok;
            logic        seg_unknown_reg;
            logic [31:0] disp_word;

            // dp is forced off so it never affects the lookup.
            assign pat    = {1'b1, frame_data_reg[14:8]};
            assign sel    = ~frame_data_reg[7:0];
            assign sel_ok = $onehot(sel);
            assign upd    = frame_valid_reg & ~frame_err_reg;
            assign dec_ok = upd & known & sel_ok;

            always_comb begin
                nib   = 4'h0;
                known = 1'b1;
                case (pat)
                    8'hC0: nib = 4'h0;
                    8'hF9: nib = 4'h1;
                    8'hA4: nib = 4'h2;
                    8'hB0: nib = 4'h3;
                    8'h99: nib = 4'h4;
                    8'h92: nib = 4'h5;
                    8'h82: nib = 4'h6;
                    8'hF8: nib = 4'h7;
                    8'h80: nib = 4'h8;
                    8'h90: nib = 4'h9;
                    8'h88: nib = 4'hA;
                    8'h83: nib = 4'hB;
                    8'hC6: nib = 4'hC;
                    8'hA1: nib = 4'hD;
                    8'h86: nib = 4'hE;
                    8'h8E: nib = 4'hF;
                    default: known = 1'b0;
                endcase
            end

            always_ff @(posedge sys_clk) begin
                if (!rst_n) seg_unknown_reg <= 1'b0;
                else        seg_unknown_reg <= upd & ~(known & sel_ok);
            end

            genvar gi;
            for (gi = 0; gi < 8; gi++) begin : g_digit
                logic [3:0] nib_reg;
                always_ff @(posedge sys_clk) begin
                    if (!rst_n)                  nib_reg <= 4'h0;
                    else if (dec_ok && sel[gi])  nib_reg <= nib;
                end
                assign disp_word[4*gi +: 4] = nib_reg;
            end

            assign bus.disp_word   = disp_word;
            assign bus.seg_unknown = seg_unknown_reg;
        end else begin : g_no_dec
            assign bus.disp_word   = '0;
            assign bus.seg_unknown = 1'b0;
        end
    endgenerate
`else
    assign bus.disp_word   = '0;
    assign bus.seg_unknown = 1'b0;
`endif
endmodule

// File: tb/tb_seg_ser_rx.sv
// Self-checking bench for seg_ser_rx: vector table, hand-written corner sequences and
// randomized frames checked against a bit-queue reference model.
module tb_seg_ser_rx;
    localparam int FB  = 16;
    localparam int TMO = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_ser_rx_if #(.FRAME_BITS(FB)) bus ();

    seg_ser_rx #(.FRAME_BITS(FB), .TIMEOUT(TMO), .SYNC_STAGES(2)) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int tmo_cnt   = 0;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) valid_cnt++;
        if (bus.timeout_err === 1'b1) tmo_cnt++;
    end

    // Reference model: every bit shifted since reset (trimmed), bits since the last latch,
    // last latched frame and expected display word.
    bit          model_bits[$];
    int          model_cnt  = 0;
    logic [15:0] model_last = '0;
    logic [31:0] model_disp = '0;
    logic [7:0]  seg_tab [16];

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_frame();
        logic [15:0] f;
        int          idx;
        f = '0;
        for (int i = 0; i < FB; i++) begin
            idx = model_bits.size() - FB + i;
            f[FB-1-i] = (idx >= 0) ? model_bits[idx] : 1'b0;
        end
        return f;
    endfunction

    task automatic model_push(input bit b);
        model_bits.push_back(b);
        if (model_bits.size() > FB) void'(model_bits.pop_front());
        model_cnt++;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        model_bits.delete();
        model_cnt  = 0;
        model_last = '0;
        model_disp = '0;
    endtask

    task automatic shift_bit(input bit b);
        bus.data_ser = b;
        repeat (2) @(negedge clk);
        bus.srclk = 1'b1;
        repeat (4) @(negedge clk);
        bus.srclk = 1'b0;
        repeat (2) @(negedge clk);
        model_push(b);
    endtask

    task automatic shift_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic latch(input string name, input bit both, input bit b,
                         output logic [15:0] got_data, output logic got_err, output logic got_unk);
        logic [15:0] exp_data;
        logic        exp_err;
        logic        exp_unk;
        int          lat;
        int          v0;
        exp_data = model_frame();
        exp_err  = (model_cnt != FB);
        exp_unk  = 1'b0;
`ifdef SEG_RX_DECODE_EN
        if (!exp_err) begin
            logic [7:0] pat;
            logic [7:0] sel;
            int         hit;
            pat = {1'b1, exp_data[14:8]};
            sel = ~exp_data[7:0];
            hit = -1;
            for (int j = 0; j < 16; j++) if (seg_tab[j] == pat) hit = j;
            if (hit >= 0 && $countones(sel) == 1) begin
                for (int d = 0; d < 8; d++) if (sel[d]) model_disp[4*d +: 4] = 4'(hit);
            end else begin
                exp_unk = 1'b1;
            end
        end
`endif
        model_cnt  = 0;
        model_last = exp_data;
        v0 = valid_cnt;
        if (both) begin
            bus.data_ser = b;
            repeat (2) @(negedge clk);
            bus.srclk = 1'b1;
            model_push(b);
        end
        bus.rclk = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.frame_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        got_data = bus.frame_data;
        got_err  = bus.frame_err;
        check({name, "_latency"}, lat, 4);
        check({name, "_data"}, got_data, exp_data);
        check({name, "_err"}, got_err, exp_err);
        @(negedge clk);
        got_unk = bus.seg_unknown;
        check({name, "_valid_pulse"}, bus.frame_valid, 1'b0);
        check({name, "_seg_unknown"}, got_unk, exp_unk);
        check({name, "_disp_word"}, bus.disp_word, model_disp);
        repeat (2) @(negedge clk);
        bus.rclk  = 1'b0;
        bus.srclk = 1'b0;
        repeat (4) @(negedge clk);
        check({name, "_valid_count"}, valid_cnt - v0, 1);
        $display("frame %s: data=%h err=%b unk=%b latency=%0d disp=%h",
                 name, got_data, got_err, got_unk, lat, bus.disp_word);
    endtask

    initial begin
        logic [15:0] d;
        logic        e;
        logic        u;
        int          bad;
        int          v0;
        int          t0;

        seg_tab[0]  = 8'hC0; seg_tab[1]  = 8'hF9; seg_tab[2]  = 8'hA4; seg_tab[3]  = 8'hB0;
        seg_tab[4]  = 8'h99; seg_tab[5]  = 8'h92; seg_tab[6]  = 8'h82; seg_tab[7]  = 8'hF8;
        seg_tab[8]  = 8'h80; seg_tab[9]  = 8'h90; seg_tab[10] = 8'h88; seg_tab[11] = 8'h83;
        seg_tab[12] = 8'hC6; seg_tab[13] = 8'hA1; seg_tab[14] = 8'h86; seg_tab[15] = 8'h8E;

        // 15-bit frame keeps one old bit (A55A LSB = 0) at the top; empty latch returns shreg.
        vecs[0] = '{32'h0000_A55A, 16, 16'hA55A, 1'b0};
        vecs[1] = '{32'h0000_1234, 15, 16'h1234, 1'b1};
        vecs[2] = '{32'h0001_2345, 17, 16'h2345, 1'b1};
        vecs[3] = '{32'h0000_0000,  0, 16'h2345, 1'b1};
        vecs[4] = '{32'h0000_BEEF, 16, 16'hBEEF, 1'b0};

        bus.data_ser = 1'b0;
        bus.srclk    = 1'b0;
        bus.rclk     = 1'b0;

        // Reset, then quiet idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_frame_data", bus.frame_data, 16'h0);
        check("reset_pulses", {bus.frame_valid, bus.frame_err, bus.timeout_err, bus.seg_unknown}, 4'h0);
        check("reset_disp_word", bus.disp_word, 32'h0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.frame_data !== 16'h0 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0 ||
                bus.timeout_err !== 1'b0 || bus.disp_word !== 32'h0 || bus.seg_unknown !== 1'b0)
                bad++;
        end
        check("idle_quiet_cycles", bad, 0);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            shift_word(vecs[i].bits, vecs[i].nbits);
            latch($sformatf("vec%0d", i), 1'b0, 1'b0, d, e, u);
            check($sformatf("vec%0d_table_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_table_err", i), e, vecs[i].exp_err);
        end

        // Coincident srclk/rclk: latch takes 00FF, the new 1 starts the next frame
        shift_word(32'h00FF, 16);
        latch("same_cycle", 1'b1, 1'b1, d, e, u);
        check("same_cycle_table_data", d, 16'h00FF);
        shift_word(32'h2AAA, 15);
        latch("after_same_cycle", 1'b0, 1'b0, d, e, u);
        check("after_same_cycle_table_data", d, 16'hAAAA);
        check("after_same_cycle_table_err", e, 1'b0);

        // Timeout on a 5-bit partial frame
        t0 = tmo_cnt;
        v0 = valid_cnt;
        shift_word(32'h15, 5);
        repeat (TMO + 50) @(negedge clk);
        model_cnt = 0;
        check("timeout_pulses", tmo_cnt - t0, 1);
        check("timeout_no_valid", valid_cnt - v0, 0);
        check("timeout_frame_kept", bus.frame_data, model_last);
        shift_word(32'h5A5A, 16);
        latch("after_timeout", 1'b0, 1'b0, d, e, u);
        check("after_timeout_table_err", e, 1'b0);

        // Reset mid-frame drops the partial data
        v0 = valid_cnt;
        shift_word(32'h5, 3);
        do_reset(1);
        repeat (20) @(negedge clk);
        check("midreset_frame_data", bus.frame_data, 16'h0);
        check("midreset_no_valid", valid_cnt - v0, 0);
        shift_word(32'h1357, 16);
        latch("after_midreset", 1'b0, 1'b0, d, e, u);
        check("after_midreset_table_err", e, 1'b0);

        // Display decode sequence (E with dp lit on digit 3)
        do_reset(1);
        shift_word(32'hF9FE, 16);
        latch("dec_1", 1'b0, 1'b0, d, e, u);
        shift_word(32'hA4FD, 16);
        latch("dec_2", 1'b0, 1'b0, d, e, u);
        shift_word(32'h06F7, 16);
        latch("dec_E", 1'b0, 1'b0, d, e, u);
`ifdef SEG_RX_DECODE_EN
        check("dec_word", bus.disp_word, 32'h0000_E021);
`else
        check("dec_word_tied", bus.disp_word, 32'h0);
`endif
        shift_word(32'hFFFE, 16);
        latch("dec_unknown", 1'b0, 1'b0, d, e, u);
`ifdef SEG_RX_DECODE_EN
        check("dec_unknown_pulse", u, 1'b1);
        check("dec_unknown_word", bus.disp_word, 32'h0000_E021);
`else
        check("dec_unknown_tied", u, 1'b0);
`endif

        // Randomized frames against the model
        for (int r = 0; r < 25; r++) begin
            int   nb;
            logic [31:0] w;
            bit   both;
            nb   = ($urandom_range(0, 1) == 1) ? 16 : int'($urandom_range(0, 19));
            w    = $urandom;
            both = ($urandom_range(0, 4) == 0);
            shift_word(w, nb);
            repeat ($urandom_range(0, 30)) @(negedge clk);
            latch($sformatf("rand%0d", r), both, 1'($urandom_range(0, 1)), d, e, u);
        end

        repeat (10) @(negedge clk);
        check("total_timeout_pulses", tmo_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
